// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB software register bank: FSM states,
// register stride, byte-enable mask generation and address-to-word decode.
package opb_regbank_pkg;

  typedef enum logic [1:0] {IDLE, ACK, GAP} state_e;

  localparam int REG_STRIDE = 4;

  // The caller assigns the ascending OPB_BE[0:3] into this [3:0] argument,
  // so be[3] is OPB_BE[0] and lands on user byte 31:24.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int j = 0; j < 4; j++) mask[8*j +: 8] = {8{be[j]}};
    return mask;
  endfunction

  function automatic logic [31:0] addr_to_index(input logic [31:0] addr,
                                                input logic [31:0] base);
    return (addr - base) >> $clog2(REG_STRIDE);
  endfunction

endpackage

// File: rtl/opb_reg_slice.sv
// One 32-bit user register with optional shadow, byte-enable write,
// commit load and a one-cycle strobe whenever the visible value updates.
module opb_reg_slice
  import opb_regbank_pkg::*;
#(
  parameter bit COMMIT_MODE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        commit,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic [31:0] data_out,
  output logic [31:0] rd_data,
  output logic        strobe
);

  logic [31:0] data_q;
  logic [31:0] shadow_q;
  logic [31:0] mask;

  assign mask = be_to_mask(wr_be);

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register (shadow included) is cleared because software reads it back.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      shadow_q <= '0;
      strobe   <= 1'b0;
    end else begin
      strobe <= COMMIT_MODE ? commit : wr_en;
      if (wr_en && COMMIT_MODE)
        shadow_q <= (shadow_q & ~mask) | (wr_data & mask);
      if (wr_en && !COMMIT_MODE)
        data_q <= (data_q & ~mask) | (wr_data & mask);
      else if (commit && COMMIT_MODE)
        data_q <= shadow_q;
    end
  end

  assign data_out = data_q;
  assign rd_data  = COMMIT_MODE ? shadow_q : data_q;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave bank of C_NUM_REGS software registers presented to Simulink logic,
// with byte-enable writes, readback, per-register strobes and optional commit.
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h00000000,
  parameter logic [31:0] C_HIGHADDR    = 32'h000000FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_REGS    = 4,
  parameter int          C_COMMIT_MODE = 0,
  parameter string       C_FAMILY      = "virtex6"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_strobe
);

  if (C_OPB_DWIDTH != 32 || C_NUM_REGS < 1 || C_NUM_REGS > 32 || C_FAMILY == "") begin : g_bad_config
    $error("opb_register_bank_ppc2simulink: unsupported configuration");
  end

  localparam logic [31:0] SPAN = C_HIGHADDR - C_BASEADDR;

  state_e      state_q, state_d;
  logic [31:0] abus, dbus, word, offset;
  logic [3:0]  be;
  logic        in_range, take, ack;
  logic [5:0]  idx_q;
  logic [31:0] data_q, rd_word;
  logic [3:0]  be_q;
  logic        rnw_q, hit_reg_q, hit_commit_q, commit_wr;
  logic [C_NUM_REGS-1:0] reg_wr;
  logic [31:0] rd_data [C_NUM_REGS];
  logic        unused_seq;

  // Ascending OPB buses map straight onto descending user vectors: DBus[0] is bit 31.
  assign abus       = OPB_ABus;
  assign dbus       = OPB_DBus;
  assign be         = OPB_BE;
  assign unused_seq = OPB_seqAddr;

  // Wrapping subtraction makes addresses below the base fall out of range too.
  assign offset   = abus - C_BASEADDR;
  assign in_range = offset <= SPAN;
  assign word     = addr_to_index(abus, C_BASEADDR);
  assign take     = (state_q == IDLE) && OPB_select && in_range;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = ACK;
      ACK:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every combinationally written signal gets a default first, so no latch.
  always_comb begin
    ack       = (state_q == ACK);
    reg_wr    = '0;
    commit_wr = 1'b0;
    if (ack && !rnw_q) begin
      for (int i = 0; i < C_NUM_REGS; i++)
        if (hit_reg_q && idx_q == 6'(i)) reg_wr[i] = 1'b1;
      commit_wr = hit_commit_q && (C_COMMIT_MODE != 0);
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      idx_q        <= '0;
      data_q       <= '0;
      be_q         <= '0;
      rnw_q        <= 1'b0;
      hit_reg_q    <= 1'b0;
      hit_commit_q <= 1'b0;
    end else if (take) begin
      idx_q        <= word[5:0];
      data_q       <= dbus;
      be_q         <= be;
      rnw_q        <= OPB_RNW;
      hit_reg_q    <= word < 32'(C_NUM_REGS);
      hit_commit_q <= word == 32'(C_NUM_REGS);
    end
  end

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
    opb_reg_slice #(.COMMIT_MODE(C_COMMIT_MODE != 0)) u_slice (
      .clk      (OPB_Clk),
      .rst      (OPB_Rst),
      .wr_en    (reg_wr[i]),
      .commit   (commit_wr),
      .wr_data  (data_q),
      .wr_be    (be_q),
      .data_out (user_data_out[32*i +: 32]),
      .rd_data  (rd_data[i]),
      .strobe   (user_strobe[i])
    );
  end

  // Commit and unused in-range addresses read as zero.
  always_comb begin
    rd_word = '0;
    if (ack && rnw_q && hit_reg_q)
      for (int i = 0; i < C_NUM_REGS; i++)
        if (idx_q == 6'(i)) rd_word = rd_data[i];
  end

  assign Sl_DBus    = rd_word;
  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: one direct-mode and one commit-mode instance,
// directed vector table, hand-written corner sequences and random transfers.
module tb_opb_register_bank_ppc2simulink;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  abus, dbus;
  logic [3:0]   be_bus;
  logic         rnw, sel_d, sel_c, seq;

  logic [31:0]  rd_d, rd_c;
  logic         ack_d, ack_c, err_d, err_c, retry_d, retry_c, tout_d, tout_c;
  logic [127:0] uo_d, uo_c;
  logic [3:0]   st_d, st_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(.C_COMMIT_MODE(0)) u_dir (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be_bus), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel_d), .OPB_seqAddr(seq),
    .Sl_DBus(rd_d), .Sl_xferAck(ack_d), .Sl_errAck(err_d), .Sl_retry(retry_d),
    .Sl_toutSup(tout_d), .user_data_out(uo_d), .user_strobe(st_d));

  opb_register_bank_ppc2simulink #(.C_COMMIT_MODE(1)) u_cmt (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be_bus), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel_c), .OPB_seqAddr(seq),
    .Sl_DBus(rd_c), .Sl_xferAck(ack_c), .Sl_errAck(err_c), .Sl_retry(retry_c),
    .Sl_toutSup(tout_c), .user_data_out(uo_c), .user_strobe(st_c));

  // Reference model: plain arrays of register contents as software sees them.
  logic [31:0] m_dir [4];
  logic [31:0] m_sh  [4];
  logic [31:0] m_out [4];

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] data,
                                            input logic [0:3] be);
    logic [31:0] res;
    res = old;
    for (int k = 0; k < 4; k++)
      if (be[k]) res[31-8*k -: 8] = data[31-8*k -: 8];
    return res;
  endfunction

  function automatic logic [31:0] ref_read(input bit cm, input logic [31:0] addr);
    int w;
    w = int'(addr / 4);
    if (w < 4) return cm ? m_sh[w] : m_dir[w];
    return 32'h0;
  endfunction

  function automatic logic [3:0] ref_strobe(input bit cm, input logic [31:0] addr, input bit rd);
    int w;
    w = int'(addr / 4);
    if (rd) return 4'h0;
    if (!cm && w < 4) return 4'(1 << w);
    if (cm && w == 4) return 4'hF;
    return 4'h0;
  endfunction

  function automatic logic [127:0] ref_outs(input bit cm);
    logic [127:0] res;
    for (int i = 0; i < 4; i++) res[32*i +: 32] = cm ? m_out[i] : m_dir[i];
    return res;
  endfunction

  task automatic ref_apply(input bit cm, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input bit rd);
    int w;
    w = int'(addr / 4);
    if (!rd) begin
      if (w < 4) begin
        if (cm) m_sh[w] = ref_merge(m_sh[w], data, be);
        else    m_dir[w] = ref_merge(m_dir[w], data, be);
      end else if (w == 4 && cm) begin
        for (int i = 0; i < 4; i++) m_out[i] = m_sh[i];
      end
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 4; i++) begin
      m_dir[i] = '0; m_sh[i] = '0; m_out[i] = '0;
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transfer: select is dropped during ACK, as a real master would.
  task automatic xfer(input bit cm, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input bit rd, input logic [31:0] exp_rd,
                      input logic [3:0] exp_st, input string tag);
    @(negedge clk);
    abus = addr; dbus = data; be_bus = be; rnw = rd;
    if (cm) sel_c = 1'b1; else sel_d = 1'b1;
    @(posedge clk); #1;
    check({tag, " ack"}, cm ? ack_c : ack_d, 1'b1);
    check({tag, " rdata"}, cm ? rd_c : rd_d, rd ? exp_rd : 32'h0);
    @(negedge clk);
    sel_c = 1'b0; sel_d = 1'b0;
    ref_apply(cm, addr, data, be, rd);
    @(posedge clk); #1;
    check({tag, " strobe"}, cm ? st_c : st_d, exp_st);
    check({tag, " user_data"}, cm ? uo_c : uo_d, ref_outs(cm));
    check({tag, " ack_one_cycle"}, cm ? ack_c : ack_d, 1'b0);
    @(posedge clk); #1;
    check({tag, " strobe_clear"}, cm ? st_c : st_d, 4'h0);
  endtask

  typedef struct {
    bit          cm;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          rd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_st;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst = 1'b1; abus = '0; dbus = '0; be_bus = '0; rnw = 1'b0;
    sel_d = 1'b0; sel_c = 1'b0; seq = 1'b0;
    ref_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset ack", {ack_d, ack_c}, 2'b00);
    check("reset rdata", {rd_d, rd_c}, 64'h0);
    check("reset user_data dir", uo_d, 128'h0);
    check("reset user_data cmt", uo_c, 128'h0);
    check("reset strobe", {st_d, st_c}, 8'h0);
    check("tied outputs", {err_d, retry_d, tout_d, err_c, retry_c, tout_c}, 6'h0);
    @(negedge clk) rst = 1'b0;

    //               cm  addr   data          be       rd  exp_rd        exp_st
    tbl.push_back('{1'b0, 32'h0,  32'h0,        4'hF,    1'b1, 32'h0,        4'h0});
    tbl.push_back('{1'b0, 32'h4,  32'h0,        4'hF,    1'b1, 32'h0,        4'h0});
    tbl.push_back('{1'b0, 32'h8,  32'h0,        4'hF,    1'b1, 32'h0,        4'h0});
    tbl.push_back('{1'b0, 32'hC,  32'h0,        4'hF,    1'b1, 32'h0,        4'h0});
    tbl.push_back('{1'b0, 32'h8,  32'hDEADBEEF, 4'b1111, 1'b0, 32'h0,        4'b0100});
    tbl.push_back('{1'b0, 32'h8,  32'h0,        4'hF,    1'b1, 32'hDEADBEEF, 4'h0});
    tbl.push_back('{1'b0, 32'h8,  32'h11223344, 4'b0100, 1'b0, 32'h0,        4'b0100});
    tbl.push_back('{1'b0, 32'h8,  32'h0,        4'hF,    1'b1, 32'hDE22BEEF, 4'h0});
    tbl.push_back('{1'b0, 32'h8,  32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0,        4'b0100});
    tbl.push_back('{1'b0, 32'h8,  32'h0,        4'hF,    1'b1, 32'hDE22BEEF, 4'h0});
    tbl.push_back('{1'b0, 32'h0,  32'hA1B2C3D4, 4'b1001, 1'b0, 32'h0,        4'b0001});
    tbl.push_back('{1'b0, 32'h0,  32'h0,        4'hF,    1'b1, 32'hA10000D4, 4'h0});
    tbl.push_back('{1'b0, 32'h10, 32'h12345678, 4'hF,    1'b0, 32'h0,        4'h0});
    tbl.push_back('{1'b0, 32'h10, 32'h0,        4'hF,    1'b1, 32'h0,        4'h0});
    tbl.push_back('{1'b0, 32'h14, 32'h0,        4'hF,    1'b1, 32'h0,        4'h0});
    tbl.push_back('{1'b1, 32'h0,  32'h5,        4'hF,    1'b0, 32'h0,        4'h0});
    tbl.push_back('{1'b1, 32'h4,  32'h7,        4'hF,    1'b0, 32'h0,        4'h0});
    tbl.push_back('{1'b1, 32'h0,  32'h0,        4'hF,    1'b1, 32'h5,        4'h0});
    tbl.push_back('{1'b1, 32'h10, 32'h0,        4'h0,    1'b0, 32'h0,        4'hF});
    tbl.push_back('{1'b1, 32'h10, 32'h0,        4'hF,    1'b1, 32'h0,        4'h0});
    tbl.push_back('{1'b1, 32'h4,  32'h0,        4'hF,    1'b1, 32'h7,        4'h0});

    for (int i = 0; i < tbl.size(); i++)
      xfer(tbl[i].cm, tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].rd,
           tbl[i].exp_rd, tbl[i].exp_st, $sformatf("vec%0d", i));

    // Select held through ACK and GAP: a single acknowledge.
    @(negedge clk);
    abus = 32'h8; rnw = 1'b1; sel_d = 1'b1; cnt = 0;
    repeat (3) begin @(posedge clk); #1; cnt += int'(ack_d); end
    @(negedge clk) sel_d = 1'b0;
    repeat (4) begin @(posedge clk); #1; cnt += int'(ack_d); end
    check("held select ack count", 32'(cnt), 32'd1);

    // Out-of-range address: no response on either instance.
    @(negedge clk);
    abus = 32'h100; rnw = 1'b0; dbus = 32'hFFFFFFFF; be_bus = 4'hF;
    sel_d = 1'b1; sel_c = 1'b1; cnt = 0;
    repeat (5) begin @(posedge clk); #1; cnt += int'(ack_d) + int'(ack_c); end
    @(negedge clk) begin sel_d = 1'b0; sel_c = 1'b0; end
    check("out of range ack count", 32'(cnt), 32'd0);
    check("out of range strobe", {st_d, st_c}, 8'h0);

    // Reset asserted in the ACK cycle of a write wins.
    @(negedge clk);
    abus = 32'h4; dbus = 32'hA5A5A5A5; be_bus = 4'hF; rnw = 1'b0; sel_d = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ack ack", ack_d, 1'b1);
    @(negedge clk) begin sel_d = 1'b0; rst = 1'b1; end
    ref_reset();
    @(posedge clk); #1;
    check("rst_in_ack ack low", ack_d, 1'b0);
    check("rst_in_ack strobe", st_d, 4'h0);
    check("rst_in_ack user_data", uo_d, 128'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ack strobe after", st_d, 4'h0);
    check("rst_in_ack user_data after", uo_d, 128'h0);
    xfer(1'b0, 32'h4, 32'h0, 4'hF, 1'b1, 32'h0, 4'h0, "rst_in_ack readback");

    // Random transfers against the model, both modes, including commit/unused words.
    for (int n = 0; n < 80; n++) begin
      bit          cm, rd;
      logic [31:0] addr, data;
      logic [3:0]  be;
      cm   = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 6) * 4);
      data = $urandom;
      be   = 4'($urandom_range(0, 15));
      rd   = 1'($urandom_range(0, 1));
      xfer(cm, addr, data, be, rd, ref_read(cm, addr), ref_strobe(cm, addr, rd),
           $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
